// File: rtl/fft_bin_streamer_if.sv
// fft_bin_streamer_if: frame-in / bin-out handshake bundle for fft_bin_streamer.
//   frame_valid_i/frame_ready_o/frame_i : parallel spectrum frame handshake
//   bin_valid_o/bin_ready_i             : one-bin-per-beat stream handshake
//   bin_re_o/bin_im_o/bin_idx_o/bin_last_o : stream payload
// Suffixes are from the streamer's point of view.
// slave modport = streamer view; master modport = producer/consumer environment view.
interface fft_bin_streamer_if #(
  parameter int unsigned POINT_FFT_POW2 = 4,
  parameter int unsigned FRAC_BITS      = 15
);
  localparam int unsigned POINT_FFT = 1 << POINT_FFT_POW2;

  logic                                   frame_valid_i;
  logic                                   frame_ready_o;
  logic [POINT_FFT-1:0][1:0][FRAC_BITS:0] frame_i;
  logic                                   bin_valid_o;
  logic                                   bin_ready_i;
  logic [FRAC_BITS:0]                     bin_re_o;
  logic [FRAC_BITS:0]                     bin_im_o;
  logic [POINT_FFT_POW2-1:0]              bin_idx_o;
  logic                                   bin_last_o;

  modport slave (
    input  frame_valid_i, frame_i, bin_ready_i,
    output frame_ready_o, bin_valid_o, bin_re_o, bin_im_o, bin_idx_o, bin_last_o
  );

  modport master (
    output frame_valid_i, frame_i, bin_ready_i,
    input  frame_ready_o, bin_valid_o, bin_re_o, bin_im_o, bin_idx_o, bin_last_o
  );
endinterface

// File: rtl/fft_bin_streamer.sv
// fft_bin_streamer: captures one parallel FFT spectrum frame and replays it one
// complex bin per beat on a valid/ready stream. The next frame is captured on the
// final beat, so back-to-back frames stream without a bubble.
// Ports:
//   clk_i  : clock, rising edge
//   rst_ni : asynchronous active-low reset
//   bus    : fft_bin_streamer_if.slave (frame handshake in, bin stream out)
// Configuration macro FFT_STREAM_HALF_EN: when defined only bins 0..N/2 are
// stored and streamed; otherwise all N bins are.
module fft_bin_streamer #(
  parameter int unsigned POINT_FFT_POW2 = 4,
  parameter int unsigned FRAC_BITS      = 15
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  fft_bin_streamer_if.slave   bus
);
  localparam int unsigned IW        = POINT_FFT_POW2;
  localparam int unsigned W         = FRAC_BITS + 1;
  localparam int unsigned POINT_FFT = 1 << POINT_FFT_POW2;
`ifdef FFT_STREAM_HALF_EN
  localparam int unsigned LAST      = POINT_FFT / 2;
`else
  localparam int unsigned LAST      = POINT_FFT - 1;
`endif
  localparam int unsigned NREG      = LAST + 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(LAST);

  typedef enum logic {IDLE, STREAM} state_e;
  typedef logic [1:0][W-1:0] bin_t;

  state_e          state_q;
  logic [IW-1:0]   idx_q;
  logic            bin_valid_q;
  logic [W-1:0]    bin_re_q;
  logic [W-1:0]    bin_im_q;
  logic            bin_last_q;
  bin_t            frame_q [NREG];

  logic [IW-1:0]   idx_d;
  logic            beat_c;
  logic            at_last_c;
  logic            frame_ready_c;
  logic            capture_c;

  // Handshake decode; frame_ready is combinational so a new frame can load on the last beat
  always_comb begin
    idx_d         = idx_q + IW'(1);
    beat_c        = bin_valid_q & bus.bin_ready_i;
    at_last_c     = (idx_q == LAST_IDX);
    frame_ready_c = (state_q == IDLE) | (at_last_c & bus.bin_ready_i);
    capture_c     = frame_ready_c & bus.frame_valid_i;
  end

  // FSM, frame store and registered stream outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      bin_valid_q <= 1'b0;
      bin_re_q    <= '0;
      bin_im_q    <= '0;
      bin_last_q  <= 1'b0;
      for (int unsigned k = 0; k < NREG; k++) frame_q[k] <= '0;
    end else begin
      if (capture_c) begin
        // Bins above LAST are never stored
        for (int unsigned k = 0; k < NREG; k++) frame_q[k] <= bus.frame_i[k];
        state_q     <= STREAM;
        idx_q       <= '0;
        bin_valid_q <= 1'b1;
        bin_re_q    <= bus.frame_i[0][0];
        bin_im_q    <= bus.frame_i[0][1];
        bin_last_q  <= 1'b0;
      end else if (state_q == STREAM && beat_c) begin
        if (at_last_c) begin
          state_q     <= IDLE;
          bin_valid_q <= 1'b0;
          bin_last_q  <= 1'b0;
        end else begin
          idx_q      <= idx_d;
          bin_re_q   <= frame_q[idx_d][0];
          bin_im_q   <= frame_q[idx_d][1];
          bin_last_q <= (idx_d == LAST_IDX);
        end
      end
    end
  end

  assign bus.frame_ready_o = frame_ready_c;
  assign bus.bin_valid_o   = bin_valid_q;
  assign bus.bin_re_o      = bin_re_q;
  assign bus.bin_im_o      = bin_im_q;
  assign bus.bin_idx_o     = idx_q;
  assign bus.bin_last_o    = bin_last_q;
endmodule
